// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary fully-connected engine.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bnn_state_t;

    // $clog2 that never returns 0, so a one-neuron layer still has a 1-bit index
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 32'd1) ? 32'd1 : 32'($clog2(v));
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount over one chunk of lanes; masked lanes never count.
module bnn_xnor_popcount #(
    parameter int unsigned  LANES = 14,
    localparam int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic [LANES-1:0] valid_mask,
    output logic [CNT_W-1:0] count
);

    logic [LANES-1:0] match;

    assign match = ~(a ^ b) & valid_mask;

    always_comb begin
        count = '0;
        for (int i = 0; i < LANES; i++) begin
            count = count + CNT_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_fc_engine.sv
// Time-multiplexed XNOR-popcount dense layer: LANES bits per cycle, one neuron at a time,
// producing a thresholded sign vector plus argmax index and score.
module bnn_fc_engine
    import bnn_pkg::*;
#(
    parameter int unsigned  N_IN   = 196,
    parameter int unsigned  N_OUT  = 10,
    parameter int unsigned  LANES  = 14,
    parameter int unsigned  THRESH = N_IN / 2,
    localparam int unsigned CNT_W  = $clog2(N_IN + 1),
    localparam int unsigned IDX_W  = clog2_min1(N_OUT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_IN-1:0]        act_in,
    input  logic [N_IN*N_OUT-1:0]  weights,
    output logic                   busy,
    output logic                   done,
    output logic [N_OUT-1:0]       out_bits,
    output logic [IDX_W-1:0]       answer,
    output logic [CNT_W-1:0]       score
);

    localparam int unsigned CHUNKS = (N_IN + LANES - 1) / LANES;
    localparam int unsigned PAD_W  = CHUNKS * LANES;
    localparam int unsigned C_W    = clog2_min1(CHUNKS);
    localparam int unsigned PC_W   = $clog2(LANES + 1);

    bnn_state_t         state_q, state_d;
    logic [N_IN-1:0]    act_q, act_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N_OUT-1:0]   out_bits_q, out_bits_d;
    logic [IDX_W-1:0]   answer_q, answer_d;
    logic [CNT_W-1:0]   score_q, score_d;

    logic [PAD_W-1:0]   act_pad, w_pad, mask_pad;
    logic [LANES-1:0]   act_chunk, w_chunk, mask_chunk;
    logic [PC_W-1:0]    chunk_cnt;
    logic [CNT_W-1:0]   final_c;
    logic               last_chunk, last_neuron;

    // Zero-padded views; the mask keeps padding lanes out of the count
    assign act_pad    = PAD_W'(act_q);
    assign w_pad      = PAD_W'(weights[32'(n_q) * N_IN +: N_IN]);
    assign mask_pad   = PAD_W'({N_IN{1'b1}});
    assign act_chunk  = act_pad[32'(c_q) * LANES +: LANES];
    assign w_chunk    = w_pad[32'(c_q) * LANES +: LANES];
    assign mask_chunk = mask_pad[32'(c_q) * LANES +: LANES];

    bnn_xnor_popcount #(.LANES(LANES)) u_popcount (
        .a          (act_chunk),
        .b          (w_chunk),
        .valid_mask (mask_chunk),
        .count      (chunk_cnt)
    );

    assign final_c     = acc_q + CNT_W'(chunk_cnt);
    assign last_chunk  = (c_q == C_W'(CHUNKS - 1));
    assign last_neuron = (n_q == IDX_W'(N_OUT - 1));

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        n_d        = n_q;
        c_d        = c_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        out_bits_d = out_bits_q;
        answer_d   = answer_q;
        score_d    = score_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    act_d      = act_in;
                    n_d        = '0;
                    c_d        = '0;
                    acc_d      = '0;
                    busy_d     = 1'b1;
                    out_bits_d = '0;
                    answer_d   = '0;
                    score_d    = '0;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    out_bits_d[n_q] = (32'(final_c) >= THRESH);
                    // Strict compare so ties keep the lowest neuron index
                    if (final_c > score_q) begin
                        score_d  = final_c;
                        answer_d = n_q;
                    end
                    acc_d = '0;
                    c_d   = '0;
                    if (last_neuron) begin
                        n_d     = '0;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        n_d = n_q + IDX_W'(1);
                    end
                end else begin
                    acc_d = final_c;
                    c_d   = c_q + C_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            act_q      <= '0;
            n_q        <= '0;
            c_q        <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_bits_q <= '0;
            answer_q   <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            n_q        <= n_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_bits_q <= out_bits_d;
            answer_q   <= answer_d;
            score_q    <= score_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out_bits = out_bits_q;
    assign answer   = answer_q;
    assign score    = score_q;

endmodule

// File: tb/tb_bnn_fc_engine.sv
// Scoreboard bench: a small 8x3 engine for directed corner cases and the default-size
// engine for randomized runs, both checked against a plain-arithmetic reference model.
module tb_bnn_fc_engine;

    localparam int LAT_S = 3 * ((8 + 3 - 1) / 3) + 1;
    localparam int LAT_B = 10 * ((196 + 14 - 1) / 14) + 1;

    typedef struct {
        int     ob;
        int     ans;
        int     sc;
        longint due;
    } exp_t;

    logic clk = 1'b0;
    longint cyc = 0;
    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic b_en = 1'b0;
    exp_t q_s[$];
    exp_t q_b[$];

    logic          s_reset, s_start, s_busy, s_done;
    logic [7:0]    s_act;
    logic [23:0]   s_w;
    logic [2:0]    s_out_bits;
    logic [1:0]    s_answer;
    logic [3:0]    s_score;

    logic          b_reset, b_start, b_busy, b_done;
    logic [195:0]  b_act;
    logic [1959:0] b_w;
    logic [9:0]    b_out_bits;
    logic [3:0]    b_answer;
    logic [7:0]    b_score;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bnn_fc_engine #(.N_IN(8), .N_OUT(3), .LANES(3), .THRESH(4)) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .act_in(s_act), .weights(s_w),
        .busy(s_busy), .done(s_done), .out_bits(s_out_bits), .answer(s_answer), .score(s_score)
    );

    bnn_fc_engine u_big (
        .clk(clk), .reset(b_reset), .start(b_start), .act_in(b_act), .weights(b_w),
        .busy(b_busy), .done(b_done), .out_bits(b_out_bits), .answer(b_answer), .score(b_score)
    );

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: score_n = number of positions where act and w_n agree
    function automatic exp_t ref_model(input int nin, input int nout, input int thr,
                                       input logic [195:0] act, input logic [1959:0] w,
                                       input longint due);
        exp_t e;
        int s;
        e.ob = 0; e.ans = 0; e.sc = 0; e.due = due;
        for (int n = 0; n < nout; n++) begin
            s = 0;
            for (int i = 0; i < nin; i++) if (act[i] == w[n*nin + i]) s++;
            if (s >= thr) e.ob = e.ob | (1 << n);
            if (s > e.sc) begin e.sc = s; e.ans = n; end
        end
        return e;
    endfunction

    function automatic exp_t mk(input int ob, input int ans, input int sc, input longint due);
        exp_t e;
        e.ob = ob; e.ans = ans; e.sc = sc; e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin : mon_small
        exp_t e;
        logic exp_busy;
        if (chk_en) begin
            exp_busy = (q_s.size() != 0) && (cyc > q_s[0].due - LAT_S) && (cyc < q_s[0].due);
            chk("s_busy", longint'(s_busy), longint'(exp_busy));
            if (s_done) begin
                if (q_s.size() == 0) chk("s_unexpected_done", longint'(s_done), 0);
                else begin
                    e = q_s.pop_front();
                    chk("s_latency", cyc, e.due);
                    chk("s_out_bits", longint'(s_out_bits), longint'(e.ob));
                    chk("s_answer", longint'(s_answer), longint'(e.ans));
                    chk("s_score", longint'(s_score), longint'(e.sc));
                end
            end else if (q_s.size() != 0 && cyc >= q_s[0].due) begin
                e = q_s.pop_front();
                chk("s_done_at_due", longint'(s_done), 1);
            end
        end
    end

    always @(negedge clk) begin : mon_big
        exp_t e;
        if (b_en) begin
            if (b_done) begin
                if (q_b.size() == 0) chk("b_unexpected_done", longint'(b_done), 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_latency", cyc, e.due);
                    chk("b_busy_at_done", longint'(b_busy), 0);
                    chk("b_out_bits", longint'(b_out_bits), longint'(e.ob));
                    chk("b_answer", longint'(b_answer), longint'(e.ans));
                    chk("b_score", longint'(b_score), longint'(e.sc));
                end
            end else if (q_b.size() != 0 && cyc >= q_b[0].due) begin
                e = q_b.pop_front();
                chk("b_done_at_due", longint'(b_done), 1);
            end
        end
    end

    task automatic wait_small();
        for (int i = 0; i < LAT_S + 20; i++) begin
            @(negedge clk);
            if (q_s.size() == 0) break;
        end
        if (q_s.size() != 0) begin
            chk("s_timeout", longint'(q_s.size()), 0);
            q_s.delete();
        end
    endtask

    // directed=1 uses the supplied constants, otherwise the reference model
    task automatic go_small(input logic [7:0] act, input logic [23:0] w,
                            input int ob, input int ans, input int sc, input bit directed);
        exp_t e;
        @(negedge clk);
        s_act = act; s_w = w; s_start = 1'b1;
        if (directed) e = mk(ob, ans, sc, cyc + LAT_S);
        else e = ref_model(8, 3, 4, 196'(act), 1960'(w), cyc + LAT_S);
        q_s.push_back(e);
        @(negedge clk);
        s_start = 1'b0;
        wait_small();
    endtask

    task automatic go_big(input logic [195:0] act, input logic [1959:0] w);
        @(negedge clk);
        b_act = act; b_w = w; b_start = 1'b1;
        q_b.push_back(ref_model(196, 10, 98, act, w, cyc + LAT_B));
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < LAT_B + 20; i++) begin
            @(negedge clk);
            if (q_b.size() == 0) break;
        end
        if (q_b.size() != 0) begin
            chk("b_timeout", longint'(q_b.size()), 0);
            q_b.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [195:0]  ra;
        logic [1959:0] rw;
        s_reset = 1'b1; b_reset = 1'b1; s_start = 1'b0; b_start = 1'b0;
        s_act = '0; s_w = '0; b_act = '0; b_w = '0;
        repeat (3) @(negedge clk);
        s_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        chk("rst_s_busy", longint'(s_busy), 0);
        chk("rst_s_done", longint'(s_done), 0);
        chk("rst_s_out_bits", longint'(s_out_bits), 0);
        chk("rst_s_answer", longint'(s_answer), 0);
        chk("rst_s_score", longint'(s_score), 0);
        chk("rst_b_busy", longint'(b_busy), 0);
        chk("rst_b_score", longint'(b_score), 0);
        chk_en = 1'b1;
        b_en = 1'b1;

        // Directed cases; weights packed as {w2, w1, w0}
        go_small(8'hFF, {8'h00, 8'h0F, 8'hFF}, 3, 0, 8, 1'b1);
        go_small(8'h00, {8'h00, 8'hFF, 8'hFF}, 4, 2, 8, 1'b1);
        go_small(8'hA5, {3{8'hA5}}, 7, 0, 8, 1'b1);
        go_small(8'hA5, {3{8'h5A}}, 0, 0, 0, 1'b1);

        // start held high through a whole run while act_in toggles
        @(negedge clk);
        s_act = 8'hFF; s_w = {8'h00, 8'h0F, 8'hFF}; s_start = 1'b1;
        q_s.push_back(mk(3, 0, 8, cyc + LAT_S));
        for (int j = 0; j < LAT_S; j++) begin
            @(negedge clk);
            s_act = ~s_act;
        end
        @(negedge clk);
        s_start = 1'b0;
        repeat (15) @(negedge clk);

        // Reset in the middle of a run
        chk_en = 1'b0;
        @(negedge clk);
        s_act = 8'hFF; s_w = {8'h00, 8'h0F, 8'hFF}; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", longint'(s_busy), 1);
        chk("mid_score", longint'(s_score), 8);
        chk("mid_out_bits", longint'(s_out_bits), 1);
        s_reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", longint'(s_busy), 0);
        chk("post_rst_done", longint'(s_done), 0);
        chk("post_rst_out_bits", longint'(s_out_bits), 0);
        chk("post_rst_answer", longint'(s_answer), 0);
        chk("post_rst_score", longint'(s_score), 0);
        s_reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        go_small(8'hFF, {8'h00, 8'h0F, 8'hFF}, 3, 0, 8, 1'b1);

        for (int r = 0; r < 40; r++) go_small(8'($urandom), 24'($urandom), 0, 0, 0, 1'b0);

        // Default-size engine: equal/opposite weight corners, then random
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < 196; i++) ra[i] = 1'($urandom_range(0, 1));
            if (r == 0) rw = {10{ra}};
            else if (r == 1) rw = {10{~ra}};
            else for (int i = 0; i < 1960; i++) rw[i] = 1'($urandom_range(0, 1));
            go_big(ra, rw);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
